// File: rtl/fft_sequencer.sv
// Run sequencer for the radix-2 FFT core: loads N samples, steps the stage
// controller through every butterfly pass, then unloads N results.
module fft_sequencer #(
    parameter int NUMSTAGES  = 5,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 load_we,
    output logic [NUMSTAGES-1:0] load_addr,
    output logic                 stage_en,
    output logic [2:0]           stage_num,
    input  logic                 stage_done,
    output logic                 unload_valid,
    input  logic                 unload_ready,
    output logic [NUMSTAGES-1:0] unload_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [NUMSTAGES-1:0] LAST_IDX   = '1;
    localparam logic [2:0]           LAST_STAGE = 3'(NUMSTAGES - 1);
    localparam logic [TW-1:0]        TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]        GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STAGE, S_GAP, S_UNLOAD, S_DONE, S_ERROR
    } state_t;

    state_t               r_state;
    logic [NUMSTAGES-1:0] r_idx;
    logic [2:0]           r_stage;
    logic [GW-1:0]        r_gap;
    logic [TW-1:0]        r_tmo;
    logic                 r_done_q;
    logic                 w_toggle;

    // stage_done is a toggle flag: any change since last cycle is a completion
    assign w_toggle = stage_done ^ r_done_q;

    always_ff @(posedge clk) begin
        r_done_q <= stage_done;
        if (!rst_n || abort) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_stage <= '0;
            r_gap   <= '0;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                        r_stage <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_STAGE;
                            r_idx   <= '0;
                            r_stage <= '0;
                            r_tmo   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_STAGE: begin
                    r_tmo <= r_tmo + 1'b1;
                    // a completion in the same cycle as the timeout still counts
                    if (w_toggle) begin
                        if (r_stage == LAST_STAGE) begin
                            r_state <= S_UNLOAD;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_GAP;
                            r_stage <= r_stage + 1'b1;
                            r_gap   <= '0;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= S_ERROR;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_STAGE;
                        r_tmo   <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (unload_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_stage <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the state register only; load_we is the one input-gated strobe
    assign load_ready   = (r_state == S_LOAD);
    assign load_we      = load_valid & load_ready;
    assign load_addr    = load_ready ? r_idx : '0;
    assign stage_en     = (r_state == S_STAGE);
    assign stage_num    = r_stage;
    assign unload_valid = (r_state == S_UNLOAD);
    assign unload_addr  = unload_valid ? r_idx : '0;
    assign busy         = (r_state == S_LOAD) || (r_state == S_STAGE) ||
                          (r_state == S_GAP)  || (r_state == S_UNLOAD);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: directed and randomized runs compared against a
// transaction-level timeline (expected handshakes, stage cycles, done/error time).
module tb_fft_sequencer;

    localparam int NS   = 5;
    localparam int NPTS = 1 << NS;
    localparam int GAP  = 1;
    localparam int TMO  = 64;
    localparam int MAXC = 1024;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic rst_n, start, abort, load_valid, unload_ready;
    logic stage_done = 1'b0;
    logic load_ready, load_we, stage_en, unload_valid, busy, done, error;
    logic [NS-1:0] load_addr, unload_addr;
    logic [2:0] stage_num;

    fft_sequencer #(.NUMSTAGES(NS), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_valid(load_valid), .load_ready(load_ready), .load_we(load_we),
        .load_addr(load_addr), .stage_en(stage_en), .stage_num(stage_num),
        .stage_done(stage_done), .unload_valid(unload_valid),
        .unload_ready(unload_ready), .unload_addr(unload_addr),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    string cur_case = "init";

    bit lv_pat[MAXC];
    bit ur_pat[MAXC];
    int stub_t[8];
    bit glitch = 1'b0;
    int cut = -1, cut_kind = 0, spur_a = -1, spur_b = -1;

    iq_t exp_load, exp_stage, exp_unl;
    int  exp_done_c, exp_err_c;

    iq_t obs_load, obs_stage, obs_unl;
    int  obs_done_c, obs_err_c, n_done, n_busy;
    int  snap[MAXC];
    bit  running = 1'b0;
    int  t0 = 0;

    function automatic int pack_outs();
        int v;
        v = 32'(load_ready) | (32'(load_we) << 1) | (32'(stage_en) << 2) |
            (32'(unload_valid) << 3) | (32'(busy) << 4) | (32'(done) << 5) |
            (32'(error) << 6) | (32'(stage_num) << 8) |
            (32'(load_addr) << 16) | (32'(unload_addr) << 24);
        return v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s: observed %0d expected %0d", cur_case, tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input iq_t obs, input iq_t exp);
        int nbad = 0;
        check({tag, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < obs.size() && i < exp.size(); i++)
            if (obs[i] !== exp[i]) nbad++;
        check({tag, "_bad_entries"}, nbad, 0);
    endtask

    function automatic iq_t trim(iq_t q, int lim);
        iq_t r;
        foreach (q[i]) if ((q[i] >> 8) <= lim) r.push_back(q[i]);
        return r;
    endfunction

    // Stage-controller stand-in: toggles stage_done during the T-th enabled cycle,
    // so the sequencer sees the completion at the end of that cycle.
    int ecnt = 0;
    always @(negedge clk) begin
        if (stage_en) begin
            ecnt++;
            if (ecnt == stub_t[stage_num]) stage_done = ~stage_done;
        end else begin
            ecnt = 0;
            if (glitch && busy && !load_ready && !unload_valid) stage_done = ~stage_done;
        end
    end

    always @(negedge clk) begin : mon
        int c;
        if (running) begin
            c = cyc - t0;
            if (c >= 0 && c < MAXC) snap[c] = pack_outs();
            if (load_we) obs_load.push_back(c * 256 + int'(load_addr));
            if (stage_en) obs_stage.push_back(c * 256 + int'(stage_num));
            if (unload_valid && unload_ready) obs_unl.push_back(c * 256 + int'(unload_addr));
            if (done) begin
                n_done++;
                if (obs_done_c < 0) obs_done_c = c;
            end
            if (error && c >= 1 && obs_err_c < 0) obs_err_c = c;
            if (busy) n_busy++;
        end
    end

    // Expected timeline: cycle 0 carries start, LOAD begins in cycle 1.
    task automatic build_model();
        int c, k;
        bit stop;
        exp_load.delete(); exp_stage.delete(); exp_unl.delete();
        exp_done_c = -1; exp_err_c = -1;
        c = 1; k = 0;
        while (k < NPTS && c < MAXC) begin
            if (lv_pat[c]) begin exp_load.push_back(c * 256 + k); k++; end
            c++;
        end
        stop = 0;
        for (int s = 0; s < NS && !stop; s++) begin
            if (stub_t[s] == 0 || stub_t[s] > TMO) begin
                for (int j = 0; j < TMO; j++) exp_stage.push_back((c + j) * 256 + s);
                exp_err_c = c + TMO;
                stop = 1;
            end else begin
                for (int j = 0; j < stub_t[s]; j++) exp_stage.push_back((c + j) * 256 + s);
                c += stub_t[s];
                if (s < NS - 1) c += GAP;
            end
        end
        if (!stop) begin
            k = 0;
            while (k < NPTS && c < MAXC) begin
                if (ur_pat[c]) begin exp_unl.push_back(c * 256 + k); k++; end
                c++;
            end
            exp_done_c = c;
        end
        if (cut >= 0) begin
            exp_load = trim(exp_load, cut);
            exp_stage = trim(exp_stage, cut);
            exp_unl = trim(exp_unl, cut);
            if (exp_done_c > cut) exp_done_c = -1;
            if (exp_err_c > cut) exp_err_c = -1;
        end
    endtask

    task automatic set_pats(input int lvm, input int urm);
        for (int c = 0; c < MAXC; c++) begin
            lv_pat[c] = (lvm == 0) ? 1'b1 : (lvm == 1) ? c[0] : ($urandom_range(0, 3) != 0);
            ur_pat[c] = (urm == 0) ? 1'b1 : (urm == 1) ? (c % 4 == 3) : ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic set_stub(input int t);
        for (int s = 0; s < 8; s++) stub_t[s] = t;
    endtask

    task automatic run_case();
        int pt, end_c, exp_busy;
        build_model();
        obs_load.delete(); obs_stage.delete(); obs_unl.delete();
        obs_done_c = -1; obs_err_c = -1; n_done = 0; n_busy = 0;
        pt = (exp_done_c >= 0) ? exp_done_c : (exp_err_c >= 0) ? exp_err_c : cut;
        exp_busy = (exp_done_c >= 0) ? exp_done_c - 1 : (exp_err_c >= 0) ? exp_err_c - 1 : cut;
        end_c = pt + 3;
        if (end_c > MAXC - 2) end_c = MAXC - 2;
        @(posedge clk); #1;
        t0 = cyc; running = 1'b1;
        start = 1'b1; load_valid = lv_pat[0]; unload_ready = ur_pat[0];
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk); #1;
            start = (c == spur_a) || (c == spur_b);
            load_valid = lv_pat[c];
            unload_ready = ur_pat[c];
            abort = (cut_kind == 1 && c == cut);
            rst_n = !(cut_kind == 2 && c == cut);
        end
        @(negedge clk); #1;
        running = 1'b0;
        start = 1'b0; abort = 1'b0; rst_n = 1'b1; load_valid = 1'b0; unload_ready = 1'b0;
        cmp_q("load_seq", obs_load, exp_load);
        cmp_q("stage_seq", obs_stage, exp_stage);
        cmp_q("unload_seq", obs_unl, exp_unl);
        check("done_cycle", obs_done_c, exp_done_c);
        check("done_count", n_done, (exp_done_c >= 0) ? 1 : 0);
        check("error_cycle", obs_err_c, exp_err_c);
        check("busy_cycles", n_busy, exp_busy);
        if (exp_done_c >= 0) begin
            check("done_outputs", snap[exp_done_c] & ~32'h700, 32);
            check("idle_after_done", snap[exp_done_c + 1], 0);
        end
        if (exp_err_c >= 0) check("error_outputs", snap[exp_err_c] & ~32'h700, 64);
        if (cut_kind != 0) check("outputs_after_cut", snap[cut + 1], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_valid = 1'b0; unload_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cur_case = "reset";
        check("outputs_in_reset", pack_outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("outputs_idle", pack_outs(), 0);

        cur_case = "nominal";
        set_pats(0, 0); set_stub(9);
        run_case();
        check("done_at_114", obs_done_c, 114);
        check("stage_first_cycle", (obs_stage.size() > 0) ? (obs_stage[0] >> 8) : -1, 33);
        check("stage_last_cycle", (obs_stage.size() > 0) ? (obs_stage[obs_stage.size() - 1] >> 8) : -1, 81);
        check("unload_first_cycle", (obs_unl.size() > 0) ? (obs_unl[0] >> 8) : -1, 82);

        cur_case = "backpressure";
        set_pats(1, 1); set_stub(9); glitch = 1'b1;
        run_case();
        glitch = 1'b0;
        check("load_we_pulses", obs_load.size(), 32);

        cur_case = "timeout";
        set_pats(0, 0); set_stub(9); stub_t[2] = 0;
        run_case();
        check("error_64_after_stage2", obs_err_c, 53 + 64);

        cur_case = "restart_after_error";
        set_stub(9);
        run_case();
        check("error_before_restart", (snap[0] >> 6) & 1, 1);
        check("error_cleared", (snap[1] >> 6) & 1, 0);
        check("first_load_addr", (obs_load.size() > 0) ? (obs_load[0] & 255) : -1, 0);

        cur_case = "abort_stage3";
        set_pats(0, 0); set_stub(9); cut = 66; cut_kind = 1;
        run_case();
        check("in_stage3_at_abort", (snap[66] >> 8) & 7, 3);

        cur_case = "abort_load";
        cut = 11;
        run_case();
        check("load_addr_at_abort", (snap[11] >> 16) & 255, 10);

        cur_case = "after_abort";
        cut = -1; cut_kind = 0;
        run_case();
        check("stage_starts_at_0", (obs_stage.size() > 0) ? (obs_stage[0] & 255) : -1, 0);

        cur_case = "spurious_start_reset";
        set_pats(2, 2);
        for (int s = 0; s < 8; s++) stub_t[s] = $urandom_range(2, 20);
        build_model();
        cut = (exp_unl.size() > 0) ? (exp_unl[0] >> 8) + 5 : 200;
        cut_kind = 2; spur_a = 5; spur_b = 40;
        run_case();
        check("unloading_at_reset", (snap[cut] >> 3) & 1, 1);
        cut = -1; cut_kind = 0; spur_a = -1; spur_b = -1;

        cur_case = "toggle_at_timeout";
        set_pats(0, 0); set_stub(9); stub_t[1] = TMO;
        run_case();

        for (int r = 0; r < 4; r++) begin
            cur_case = $sformatf("random%0d", r);
            set_pats(2, 2);
            glitch = 1'($urandom_range(0, 1));
            for (int s = 0; s < 8; s++)
                stub_t[s] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
            run_case();
        end
        glitch = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Top-level run sequencer for the 32-point radix-2 FFT core. It accepts a start command and loads N = 2^NUMSTAGES samples through a valid/ready port. It then drives the stage controller's enable and stage number through all NUMSTAGES passes, advancing on each stage_done toggle. Finally it unloads N results through a valid/ready port and reports completion, or reports an error on a stalled stage.

Parameters:
NUMSTAGES, 5, number of butterfly stages; N = 2^NUMSTAGES points; legal range 3..8
GAP_CYCLES, 1, cycles stage_en is held low between stages so the stage counter clears; legal range ≥1
TIMEOUT, 64, maximum cycles in one STAGE pass before error; legal range > 2^(NUMSTAGES-2)+1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  begin a run; sampled only in IDLE or ERROR
abort  in  1  synchronous abort; takes priority over all other inputs except rst_n
load_valid  in  1  input sample present
load_ready  out  1  sequencer accepts an input sample
load_we  out  1  sample-memory write strobe = load_valid & load_ready
load_addr  out  NUMSTAGES  write address of the current input sample
stage_en  out  1  enable to the stage controller
stage_num  out  3  current stage index to the stage controller and mux/address control
stage_done  in  1  toggle-type completion flag from the stage controller
unload_valid  out  1  output sample available
unload_ready  in  1  consumer accepts output sample
unload_addr  out  NUMSTAGES  read address of the current output sample
busy  out  1  high in LOAD, STAGE, GAP and UNLOAD
done  out  1  one-cycle pulse at run completion
error  out  1  stage timeout flag; held until the next start or abort

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, and counters, stage_num, the gap counter and the timeout counter are cleared. All outputs are 0. done_q takes the current stage_done value.
- done_q samples stage_done every cycle in every state. A toggle is defined as stage_done != done_q.
- IDLE: all outputs are 0. start=1 → LOAD and idx=0.
- LOAD: load_ready=1 and load_addr=idx. On load_valid=1, idx increments. When idx=N-1 is accepted, the state moves to STAGE with stage_num=0, idx=0 and tmo=0. load_valid=0 stalls the state with no change.
- STAGE: stage_en=1 and tmo increments every cycle.
  - On a toggle with stage_num=NUMSTAGES-1 → UNLOAD with idx=0.
  - On a toggle with stage_num<NUMSTAGES-1 → GAP, stage_num increments and the gap counter is cleared.
  - If tmo reaches TIMEOUT-1 with no toggle → ERROR. If the toggle and the timeout occur in the same cycle, the toggle wins.
- GAP: stage_en=0 for exactly GAP_CYCLES cycles, then → STAGE with tmo=0. A toggle seen during GAP is ignored; done_q still tracks it.
- UNLOAD: unload_valid=1 and unload_addr=idx. On unload_ready=1, idx increments. When idx=N-1 is accepted → DONE.
- DONE: done=1 for one cycle, busy=0, then → IDLE. start is ignored in this cycle.
- ERROR: error=1, busy=0, stage_en=0. start=1 → LOAD, with error cleared on the same edge.
- Abort: abort=1 in any state → IDLE on the next edge, with the same state as reset except that done_q keeps tracking.
- stage_num: held constant while in STAGE. It is not wrapped; its maximum is NUMSTAGES-1.
- idx arithmetic: idx is NUMSTAGES bits wide. No wrap is ever observed, because the terminal compare exits first.
- Timing: all outputs are registered or decoded from state only. There is no combinational path from inputs to outputs, except load_we (AND with load_valid).

Test Plan:
1. Nominal run, N=32. rst_n released; start at cycle 0; load_valid and unload_ready held high. The stage stub toggles stage_done on the 8th enabled edge. Required:
   - load_ready in cycles 1–32, load_addr 0..31.
   - stage_en high 9 cycles per stage with stage_num 0..4, and low for 1 cycle between stages; stage period is cycles 33–81.
   - unload_valid in cycles 82–113, unload_addr 0..31.
   - done pulse in cycle 114, busy low from cycle 114.
2. Backpressure: load_valid toggles 1,0,1,0 and unload_ready is low for 3 of every 4 cycles. Required: load_addr and unload_addr advance only on handshake, with no skipped or repeated address; exactly 32 load_we pulses.
3. Timeout: the stub never toggles in stage 2. Required: ERROR entered 64 cycles after stage 2 starts; error=1, stage_en=0, busy=0. A later start clears error and load_addr restarts at 0.
4. Abort mid-STAGE 3 and mid-LOAD at idx=10. Required: IDLE next cycle with all outputs 0. A new start performs a complete nominal run, with stage_num starting at 0.
5. Spurious start while busy, plus rst_n=0 during UNLOAD. Required: the start is ignored with no address restart. The reset gives all outputs 0 on the next edge, and no done pulse is emitted.
6. Toggle coincident with timeout (stub toggles at tmo=63). Required: the sequencer advances to GAP with stage_num incremented, and error stays 0.
